dram_reset_sequencer: RTL and testbench



---
 rtl/dram_rst_pkg.sv | 27 ++
 rtl/dram_reset_sequencer_sync_2ff.sv | 31 +++
 rtl/dram_reset_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_dram_reset_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_rst_pkg.sv
// Shared types and elaboration helpers for the DRAM reset sequencer.
package dram_rst_pkg;

   // Bring-up sequence states
   typedef enum logic [2:0] {
      ST_WAIT_LOCK  = 3'd0,
      ST_POR_WAIT   = 3'd1,
      ST_ECLK_STOP  = 3'd2,
      ST_DLL_UPD    = 3'd3,
      ST_DLL_WAIT   = 3'd4,
      ST_ECLK_START = 3'd5,
      ST_RELEASE    = 3'd6,
      ST_RUN        = 3'd7
   } state_e;

   // Power-up hold length in clk cycles
   function automatic int unsigned por_cycles(input int unsigned clk_freq_hz,
                                              input int unsigned por_delay_us);
      return (clk_freq_hz / 32'd1_000_000) * por_delay_us;
   endfunction

   // Larger of two unsigned values, used to size the shared counter
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dram_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the async level through two stages
   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   // Synchronizer flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/dram_reset_sequencer.sv
// DRAM-side reset and ECLK/DDRDLL bring-up sequencer for the DDR3 PHY clocking.
module dram_reset_sequencer
   import dram_rst_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned POR_DELAY_US = 650,
   parameter int unsigned LOCK_FILTER  = 16,
   parameter int unsigned STOP_CYCLES  = 8,
   parameter int unsigned UPD_CYCLES   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic ddrdll_lock,
   input  logic soft_rst,
   output logic eclk_stop,
   output logic ddrdll_uddcntln,
   output logic sync2x_rst,
   output logic dramsync_rst,
   output logic ready
);

   localparam int unsigned POR_CYCLES = por_cycles(CLK_FREQ_HZ, POR_DELAY_US);
   localparam int unsigned MAX_LOAD   = max_u(max_u(POR_CYCLES, LOCK_FILTER),
                                              max_u(STOP_CYCLES, UPD_CYCLES));
   localparam int unsigned CNT_W      = $clog2(MAX_LOAD + 1);

   localparam logic [CNT_W-1:0] LD_FILTER = CNT_W'(LOCK_FILTER);
   localparam logic [CNT_W-1:0] LD_POR    = CNT_W'(POR_CYCLES);
   localparam logic [CNT_W-1:0] LD_STOP   = CNT_W'(STOP_CYCLES);
   localparam logic [CNT_W-1:0] LD_UPD    = CNT_W'(UPD_CYCLES);

   // A zero load would make the down-counter wrap instead of expiring
   if (LOCK_FILTER == 0 || POR_CYCLES == 0 || STOP_CYCLES == 0 || UPD_CYCLES == 0) begin : g_bad_load
      $error("dram_reset_sequencer: all counter loads must be non-zero");
   end

   logic pll_lock_sync;
   logic dll_lock_sync;

   sync_2ff u_pll_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (pll_locked),
      .sync_o  (pll_lock_sync)
   );

   sync_2ff u_dll_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ddrdll_lock),
      .sync_o  (dll_lock_sync)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             eclk_stop_q, eclk_stop_d;
   logic             uddcntln_q, uddcntln_d;
   logic             sync2x_rst_q, sync2x_rst_d;
   logic             dramsync_rst_q, dramsync_rst_d;
   logic             ready_q, ready_d;

   logic [CNT_W-1:0] cnt_dec;
   logic             cnt_last;
   logic             restart;

   // Shared down-counter helpers and the restart condition
   always_comb begin
      cnt_dec  = cnt_q - CNT_W'(1);
      cnt_last = (cnt_q == CNT_W'(1));
      restart  = soft_rst || (!pll_lock_sync && (state_q != ST_WAIT_LOCK));
   end

   // Next state, counter and registered-output values
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      eclk_stop_d    = eclk_stop_q;
      uddcntln_d     = uddcntln_q;
      sync2x_rst_d   = sync2x_rst_q;
      dramsync_rst_d = dramsync_rst_q;
      ready_d        = ready_q;

      if (restart) begin
         state_d        = ST_WAIT_LOCK;
         cnt_d          = LD_FILTER;
         eclk_stop_d    = 1'b1;
         uddcntln_d     = 1'b1;
         sync2x_rst_d   = 1'b1;
         dramsync_rst_d = 1'b1;
         ready_d        = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               // Counter holds the number of clean lock cycles still needed
               if (!pll_lock_sync) begin
                  cnt_d = LD_FILTER;
               end else if (cnt_last) begin
                  state_d = ST_POR_WAIT;
                  cnt_d   = LD_POR;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
            ST_POR_WAIT: begin
               if (cnt_last) begin
                  state_d = ST_ECLK_STOP;
                  cnt_d   = LD_STOP;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
            ST_ECLK_STOP: begin
               eclk_stop_d = 1'b1;
               if (cnt_last) begin
                  state_d    = ST_DLL_UPD;
                  cnt_d      = LD_UPD;
                  uddcntln_d = 1'b0;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
            ST_DLL_UPD: begin
               if (cnt_last) begin
                  state_d    = ST_DLL_WAIT;
                  uddcntln_d = 1'b1;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
            ST_DLL_WAIT: begin
               // No timeout: the DLL must lock before ECLK restarts
               if (dll_lock_sync) begin
                  state_d      = ST_ECLK_START;
                  cnt_d        = LD_STOP;
                  eclk_stop_d  = 1'b0;
                  sync2x_rst_d = 1'b0;
               end
            end
            ST_ECLK_START: begin
               if (cnt_last) begin
                  state_d = ST_RELEASE;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
            ST_RELEASE: begin
               state_d        = ST_RUN;
               dramsync_rst_d = 1'b0;
               ready_d        = 1'b1;
            end
            ST_RUN: begin
               // Hold; DLL lock loss is deliberately ignored here
            end
            default: begin
               state_d        = ST_WAIT_LOCK;
               cnt_d          = LD_FILTER;
               eclk_stop_d    = 1'b1;
               uddcntln_d     = 1'b1;
               sync2x_rst_d   = 1'b1;
               dramsync_rst_d = 1'b1;
               ready_d        = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_WAIT_LOCK;
         cnt_q          <= LD_FILTER;
         eclk_stop_q    <= 1'b1;
         uddcntln_q     <= 1'b1;
         sync2x_rst_q   <= 1'b1;
         dramsync_rst_q <= 1'b1;
         ready_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         eclk_stop_q    <= eclk_stop_d;
         uddcntln_q     <= uddcntln_d;
         sync2x_rst_q   <= sync2x_rst_d;
         dramsync_rst_q <= dramsync_rst_d;
         ready_q        <= ready_d;
      end
   end

   assign eclk_stop       = eclk_stop_q;
   assign ddrdll_uddcntln = uddcntln_q;
   assign sync2x_rst      = sync2x_rst_q;
   assign dramsync_rst    = dramsync_rst_q;
   assign ready           = ready_q;

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// Self-checking bench for dram_reset_sequencer (power-up hold shortened to 1000 cycles).
module tb_dram_reset_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_locked = 1'b1;
   logic ddrdll_lock = 1'b1;
   logic soft_rst = 1'b0;
   logic eclk_stop, ddrdll_uddcntln, sync2x_rst, dramsync_rst, ready;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   dram_reset_sequencer #(
      .CLK_FREQ_HZ  (100_000_000),
      .POR_DELAY_US (10),
      .LOCK_FILTER  (16),
      .STOP_CYCLES  (8),
      .UPD_CYCLES   (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .ddrdll_lock     (ddrdll_lock),
      .soft_rst        (soft_rst),
      .eclk_stop       (eclk_stop),
      .ddrdll_uddcntln (ddrdll_uddcntln),
      .sync2x_rst      (sync2x_rst),
      .dramsync_rst    (dramsync_rst),
      .ready           (ready)
   );

   // Output vector order: {eclk_stop, uddcntln, sync2x_rst, dramsync_rst, ready}
   localparam logic [4:0] O_RST   = 5'b11110;
   localparam logic [4:0] O_UPD   = 5'b10110;
   localparam logic [4:0] O_START = 5'b01010;
   localparam logic [4:0] O_RUN   = 5'b01001;

   typedef struct {
      int         edge_n;
      logic [4:0] outs;
      string      name;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [4:0] outs_now();
      return {eclk_stop, ddrdll_uddcntln, sync2x_rst, dramsync_rst, ready};
   endfunction

   task automatic check_int(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_outs(input string nm, input logic [4:0] exp);
      n_checks++;
      if (outs_now() !== exp) begin
         n_fail++;
         $display("FAIL %s: {eclk_stop,uddcntln,sync2x,dramsync,ready} got %b expected %b at cycle %0d",
                  nm, outs_now(), exp, cyc);
      end
   endtask

   // One clock: sample 1 time unit after the rising edge, checking the update/stop invariant
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      n_checks++;
      if (ddrdll_uddcntln === 1'b0 && eclk_stop !== 1'b1) begin
         n_fail++;
         $display("FAIL udd_only_when_stopped: uddcntln=%b eclk_stop=%b at cycle %0d",
                  ddrdll_uddcntln, eclk_stop, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_release(input int bound, output int t_s2x, output int t_drm);
      t_s2x = -1;
      t_drm = -1;
      for (int n = 0; n < bound; n++) begin
         tick();
         if (t_s2x < 0 && sync2x_rst == 1'b0) t_s2x = cyc;
         if (dramsync_rst == 1'b0) begin
            t_drm = cyc;
            break;
         end
      end
   endtask

   int ts, td;

   initial begin
      // Nominal path, edges counted from rst_n release:
      // lock seen at 3, POR_WAIT at 18, ECLK_STOP at 1018, DLL_UPD at 1026,
      // DLL_WAIT at 1030, ECLK_START at 1031, RELEASE at 1039, RUN at 1040.
      tbl[0] = '{edge_n: 1,    outs: O_RST,   name: "nom_first_edge"};
      tbl[1] = '{edge_n: 18,   outs: O_RST,   name: "nom_lock_accept"};
      tbl[2] = '{edge_n: 1025, outs: O_RST,   name: "nom_eclk_stop_end"};
      tbl[3] = '{edge_n: 1026, outs: O_UPD,   name: "nom_upd_start"};
      tbl[4] = '{edge_n: 1029, outs: O_UPD,   name: "nom_upd_last"};
      tbl[5] = '{edge_n: 1030, outs: O_RST,   name: "nom_upd_end"};
      tbl[6] = '{edge_n: 1031, outs: O_START, name: "nom_eclk_start"};
      tbl[7] = '{edge_n: 1039, outs: O_START, name: "nom_release_state"};
      tbl[8] = '{edge_n: 1040, outs: O_RUN,   name: "nom_run"};
      tbl[9] = '{edge_n: 1045, outs: O_RUN,   name: "nom_run_hold"};

      // Reset values
      rst_n = 1'b0;
      tick();
      tick();
      check_outs("reset_values", O_RST);
      rst_n = 1'b1;
      cyc = 0;

      for (int i = 0; i < 10; i++) begin
         while (cyc < tbl[i].edge_n) tick();
         check_outs(tbl[i].name, tbl[i].outs);
      end

      // DDRDLL lock loss in RUN has no effect
      ddrdll_lock = 1'b0;
      repeat (6) tick();
      check_outs("dll_loss_in_run", O_RUN);
      ddrdll_lock = 1'b1;
      repeat (3) tick();

      // soft_rst in RUN: reset values next edge, then a full rerun (lock already synced)
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      check_outs("soft_rst_next_edge", O_RST);
      cyc = 0;
      wait_release(3000, ts, td);
      check_int("soft_rerun_dram_fall", td, 1038);
      check_int("soft_rerun_s2x_gap", td - ts, 9);
      check_outs("soft_rerun_run", O_RUN);

      // PLL lock loss in RUN: two synchronizer edges, reset values on the third
      pll_locked = 1'b0;
      tick();
      tick();
      check_outs("pll_loss_edge2", O_RUN);
      tick();
      check_outs("pll_loss_edge3", O_RST);
      pll_locked = 1'b1;
      cyc = 0;
      wait_release(3000, ts, td);
      check_int("relock_dram_fall", td, 1040);
      check_int("relock_s2x_gap", td - ts, 9);

      // Lock drop in the middle of POR_WAIT restarts the full hold after relock
      do_reset();
      while (cyc < 500) tick();
      check_outs("por_wait_mid", O_RST);
      pll_locked = 1'b0;
      repeat (20) tick();
      check_outs("por_lock_dropped", O_RST);
      pll_locked = 1'b1;
      wait_release(3000, ts, td);
      check_int("por_drop_dram_fall", td, 1560);
      check_int("por_drop_s2x_gap", td - ts, 9);

      // One-cycle lock glitch every 10 cycles for 100 cycles: filter never fills until the end
      do_reset();
      for (int i = 0; i < 100; i++) begin
         pll_locked = (i % 10 != 9);
         tick();
      end
      pll_locked = 1'b1;
      wait_release(3000, ts, td);
      check_int("glitch_dram_fall", td, 1140);
      check_outs("glitch_run", O_RUN);

      // DDRDLL slow to lock: hold in DLL_WAIT, release 2+8+1 edges after lock rises
      ddrdll_lock = 1'b0;
      do_reset();
      while (cyc < 1029) tick();
      check_outs("dllw_upd_pulse", O_UPD);
      while (cyc < 1529) tick();
      check_outs("dllw_hold", O_RST);
      ddrdll_lock = 1'b1;
      wait_release(3000, ts, td);
      check_int("dllw_s2x_fall", ts, 1532);
      check_int("dllw_dram_fall", td, 1541);

      // Asynchronous reset in ECLK_START takes effect with no clock edge
      do_reset();
      while (cyc < 1034) tick();
      check_outs("async_pre_eclk_start", O_START);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst_no_edge", O_RST);
      tick();
      check_outs("async_rst_held", O_RST);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
